// File: rtl/mul_serial_sat.sv
// rtl/mul_serial_sat.sv - serial shift-add signed Q-format multiplier with saturation
// Define MUL_SAT_ROUND_EN for round-half-up; otherwise results truncate toward -inf.
module mul_serial_sat #(
    parameter int D_W  = 16,
    parameter int FRAC = 13
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic           I_VLD,
    output logic           O_RDY,
    input  logic [D_W-1:0] I_M1,
    input  logic [D_W-1:0] I_M2,
    output logic           O_VLD,
    input  logic           I_RDY,
    output logic [D_W-1:0] O_PRODUCT,
    output logic           O_OVF
);

    localparam int AW = 2 * D_W;
    localparam int PW = AW + 1;
    localparam int CW = $clog2(D_W);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CAL  = 3'b010,
        S_OUT  = 3'b100
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] m1_q, m1_d;
    logic [D_W-1:0] m2_q, m2_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] pp;
    logic          last_step;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state_q <= S_IDLE;
            m1_q    <= '0;
            m2_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign last_step = (cnt_q == CW'(D_W - 1));

    always_comb begin
        state_d = state_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pp      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (I_VLD) begin
                    m1_d    = {{D_W{I_M1[D_W-1]}}, I_M1};
                    m2_d    = I_M2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CAL;
                end
            end
            S_CAL: begin
                pp = m2_q[cnt_q] ? (m1_q << cnt_q) : '0;
                // The multiplier MSB carries negative weight in two's complement.
                if (last_step) begin
                    acc_d   = acc_q - pp;
                    cnt_d   = '0;
                    state_d = S_OUT;
                end else begin
                    acc_d = acc_q + pp;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (I_RDY) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [PW-1:0]  p_ext, r_sum, r_shr;
    logic           fits;
    logic [D_W-1:0] sat_val;

`ifdef MUL_SAT_ROUND_EN
    localparam logic [PW-1:0] RND = PW'(1) << (FRAC - 1);
`endif

    always_comb begin
        p_ext = {acc_q[AW-1], acc_q};
`ifdef MUL_SAT_ROUND_EN
        r_sum = p_ext + RND;
`else
        r_sum = p_ext;
`endif
        r_shr = $signed(r_sum) >>> FRAC;
        // Result fits when every bit from the target sign bit upward agrees.
        fits  = (&r_shr[PW-1:D_W-1]) | ~(|r_shr[PW-1:D_W-1]);
        if (fits) begin
            sat_val = r_shr[D_W-1:0];
        end else if (r_shr[PW-1]) begin
            sat_val = {1'b1, {(D_W-1){1'b0}}};
        end else begin
            sat_val = {1'b0, {(D_W-1){1'b1}}};
        end
    end

    assign O_RDY     = (state_q == S_IDLE);
    assign O_VLD     = (state_q == S_OUT);
    assign O_PRODUCT = O_VLD ? sat_val : '0;
    assign O_OVF     = O_VLD & ~fits;

endmodule
